hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding unit for the pipelined CPU: generates ID- and EX-stage

---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: ME/WB forwarding selects, load-use stall and a per-register
// latency scoreboard for multi-cycle ops. Optional stall statistics via HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      EX_reg_write_i,
  input  logic [REG_AW-1:0]         EX_rd_i,
  input  logic                      EX_is_load_i,
  input  logic                      ME_reg_write_i,
  input  logic [REG_AW-1:0]         ME_rd_i,
  input  logic                      WB_reg_write_i,
  input  logic [REG_AW-1:0]         WB_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] ID_rs_i,
  input  logic [NUM_SRC*REG_AW-1:0] EX_rs_i,
  input  logic [REG_AW-1:0]         ID_rd_i,
  input  logic                      issue_long_i,
  input  logic [LAT_W-1:0]          issue_lat_i,
  input  logic                      flush_i,
  output logic [2*NUM_SRC-1:0]      EX_fwd_o,
  output logic [2*NUM_SRC-1:0]      ID_fwd_o,
  output logic                      stall_o,
  output logic                      busy_o,
  output logic [15:0]               stall_cnt_o
);

  localparam int NREG = 1 << REG_AW;

  logic ex_flag, me_flag, wb_flag;
  logic load_use, sb_stall, issue_acc;
  logic [LAT_W-1:0] issue_cnt;
  logic [NREG-1:0][LAT_W-1:0] sb_q, sb_d;

  assign ex_flag = EX_reg_write_i && (EX_rd_i != '0);
  assign me_flag = ME_reg_write_i && (ME_rd_i != '0);
  assign wb_flag = WB_reg_write_i && (WB_rd_i != '0);

  // ME has priority over WB because it carries the younger result.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    fwd_sel = 2'b00;
    if (rs != '0) begin
      if (me_flag && (rs == ME_rd_i))      fwd_sel = 2'b10;
      else if (wb_flag && (rs == WB_rd_i)) fwd_sel = 2'b01;
    end
  endfunction

  always_comb begin
    EX_fwd_o = '0;
    ID_fwd_o = '0;
    load_use = 1'b0;
    sb_stall = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      EX_fwd_o[2*k +: 2] = fwd_sel(EX_rs_i[k*REG_AW +: REG_AW]);
      ID_fwd_o[2*k +: 2] = fwd_sel(ID_rs_i[k*REG_AW +: REG_AW]);
      if (ID_rs_i[k*REG_AW +: REG_AW] != '0) begin
        if (ex_flag && EX_is_load_i && (EX_rd_i == ID_rs_i[k*REG_AW +: REG_AW]))
          load_use = 1'b1;
        if (sb_q[ID_rs_i[k*REG_AW +: REG_AW]] != '0)
          sb_stall = 1'b1;
      end
    end
  end

  assign stall_o = load_use | sb_stall;
  assign busy_o  = |sb_q;

  // A long op is taken only when ID actually advances; a stalled one is re-presented.
  assign issue_acc = issue_long_i && !stall_o && !flush_i && (ID_rd_i != '0);
  assign issue_cnt = (issue_lat_i == '0) ? LAT_W'(1) : issue_lat_i;

  always_comb begin
    sb_d = '0;
    for (int r = 1; r < NREG; r++)
      sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - LAT_W'(1) : '0;
    if (flush_i)        sb_d = '0;
    else if (issue_acc) sb_d[ID_rd_i] = issue_cnt;
    sb_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = (stall_o && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'h0000;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding/load-use vector table plus
// scoreboard, WAW, flush and reset sequences.
module tb_hazard_scoreboard;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int LAT_W   = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic ex_rw, ex_ld, me_rw, wb_rw, issue_long, flush;
  logic [REG_AW-1:0] ex_rd, me_rd, wb_rd, id_rd;
  logic [NUM_SRC*REG_AW-1:0] id_rs, ex_rs;
  logic [LAT_W-1:0] issue_lat;
  logic [2*NUM_SRC-1:0] ex_fwd, id_fwd;
  logic stall, busy;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  hazard_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_reg_write_i(ex_rw), .EX_rd_i(ex_rd), .EX_is_load_i(ex_ld),
    .ME_reg_write_i(me_rw), .ME_rd_i(me_rd),
    .WB_reg_write_i(wb_rw), .WB_rd_i(wb_rd),
    .ID_rs_i(id_rs), .EX_rs_i(ex_rs), .ID_rd_i(id_rd),
    .issue_long_i(issue_long), .issue_lat_i(issue_lat), .flush_i(flush),
    .EX_fwd_o(ex_fwd), .ID_fwd_o(id_fwd), .stall_o(stall), .busy_o(busy),
    .stall_cnt_o(stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       ex_rw, ex_ld, me_rw, wb_rw;
    logic [4:0] ex_rd, me_rd, wb_rd;
    logic [9:0] id_rs, ex_rs;
    logic [3:0] exp_ex_fwd, exp_id_fwd;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic erw, input logic [4:0] erd, input logic eld,
                              input logic mrw, input logic [4:0] mrd,
                              input logic wrw, input logic [4:0] wrd,
                              input logic [4:0] id1, input logic [4:0] id0,
                              input logic [4:0] ex1, input logic [4:0] ex0,
                              input logic [3:0] efw, input logic [3:0] ifw, input logic st);
    vec_t v;
    v.ex_rw = erw; v.ex_rd = erd; v.ex_ld = eld;
    v.me_rw = mrw; v.me_rd = mrd; v.wb_rw = wrw; v.wb_rd = wrd;
    v.id_rs = {id1, id0}; v.ex_rs = {ex1, ex0};
    v.exp_ex_fwd = efw; v.exp_id_fwd = ifw; v.exp_stall = st;
    return v;
  endfunction

  // scoreboard check
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    ex_rw = 0; ex_rd = '0; ex_ld = 0; me_rw = 0; me_rd = '0; wb_rw = 0; wb_rd = '0;
    id_rs = '0; ex_rs = '0; id_rd = '0; issue_long = 0; issue_lat = '0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
    issue_long = 1; id_rd = rd; issue_lat = lat;
  endtask

  task automatic no_issue();
    issue_long = 0; id_rd = '0; issue_lat = '0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic tick(input logic exp_st);
    if (exp_st) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_stats();
`ifdef HAZARD_STATS_EN
    return 16'(exp_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    vecs[0]  = mk(0,0,0, 1,5, 1,5,   0,0,   0,5,   4'b0010, 4'b0000, 0);
    vecs[1]  = mk(0,0,0, 0,5, 1,5,   0,0,   0,5,   4'b0001, 4'b0000, 0);
    vecs[2]  = mk(0,0,0, 1,0, 1,0,   0,0,   0,0,   4'b0000, 4'b0000, 0);
    vecs[3]  = mk(0,0,0, 1,3, 1,4,   3,4,   4,3,   4'b0110, 4'b1001, 0);
    vecs[4]  = mk(0,0,0, 0,3, 0,4,   3,4,   4,3,   4'b0000, 4'b0000, 0);
    vecs[5]  = mk(1,7,1, 0,0, 0,0,   7,2,   0,0,   4'b0000, 4'b0000, 1);
    vecs[6]  = mk(1,0,1, 0,0, 0,0,   0,0,   0,0,   4'b0000, 4'b0000, 0);
    vecs[7]  = mk(0,7,1, 0,0, 0,0,   7,0,   0,0,   4'b0000, 4'b0000, 0);
    vecs[8]  = mk(1,7,0, 0,0, 0,0,   0,7,   0,0,   4'b0000, 4'b0000, 0);
    vecs[9]  = mk(0,0,0, 1,31,1,31,  31,31, 31,31, 4'b1010, 4'b1010, 0);
    vecs[10] = mk(1,6,1, 1,6, 0,0,   0,6,   0,0,   4'b0000, 4'b0010, 1);
    vecs[11] = mk(0,0,0, 0,0, 1,1,   2,1,   1,1,   4'b0101, 4'b0001, 0);

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_stall", 16'(stall), 16'h0);
    chk("reset_cnt", stall_cnt, 16'h0);
    // load-use term is live even while reset holds the scoreboard
    ex_rw = 1; ex_rd = 5'd7; ex_ld = 1; id_rs = {5'd7, 5'd0};
    settle();
    chk("reset_loaduse", 16'(stall), 16'h1);
    @(posedge clk); #1;
    idle();
    rst_n = 1;
    tick(0);
    chk("reset_cnt_held", stall_cnt, exp_stats());

    for (int i = 0; i < 12; i++) begin
      ex_rw = vecs[i].ex_rw; ex_rd = vecs[i].ex_rd; ex_ld = vecs[i].ex_ld;
      me_rw = vecs[i].me_rw; me_rd = vecs[i].me_rd;
      wb_rw = vecs[i].wb_rw; wb_rd = vecs[i].wb_rd;
      id_rs = vecs[i].id_rs; ex_rs = vecs[i].ex_rs;
      settle();
      chk($sformatf("v%0d_ex_fwd", i), 16'(ex_fwd), 16'(vecs[i].exp_ex_fwd));
      chk($sformatf("v%0d_id_fwd", i), 16'(id_fwd), 16'(vecs[i].exp_id_fwd));
      chk($sformatf("v%0d_stall", i), 16'(stall), 16'(vecs[i].exp_stall));
      tick(vecs[i].exp_stall);
    end
    idle();
    settle();
    chk("table_cnt", stall_cnt, exp_stats());

    // long op rd=9 lat=3; an issue to rd=10 during the stall must be ignored
    issue(5'd9, 3'd3); settle();
    chk("lat3_issue_stall", 16'(stall), 16'h0);
    chk("lat3_issue_busy", 16'(busy), 16'h0);
    tick(0);
    issue(5'd10, 3'd5); id_rs = {5'd0, 5'd9};
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("lat3_stall_c%0d", c), 16'(stall), 16'h1);
      chk($sformatf("lat3_busy_c%0d", c), 16'(busy), 16'h1);
      tick(1);
      no_issue();
    end
    id_rs = {5'd10, 5'd9}; settle();
    chk("lat3_release", 16'(stall), 16'h0);
    chk("lat3_busy_off", 16'(busy), 16'h0);
    tick(0);

    // lat 0 is tracked as 1
    idle(); issue(5'd11, 3'd0); tick(0);
    no_issue(); id_rs = {5'd0, 5'd11}; settle();
    chk("lat0_stall", 16'(stall), 16'h1);
    tick(1);
    settle();
    chk("lat0_release", 16'(stall), 16'h0);
    tick(0);

    // WAW: lat4 then lat1 to rd=9
    idle(); issue(5'd9, 3'd4); tick(0);
    issue(5'd9, 3'd1); settle();
    chk("waw_busy", 16'(busy), 16'h1);
    tick(0);
    no_issue(); id_rs = {5'd0, 5'd9}; settle();
    chk("waw_stall", 16'(stall), 16'h1);
    tick(1);
    settle();
    chk("waw_release", 16'(stall), 16'h0);
    chk("waw_busy_off", 16'(busy), 16'h0);
    tick(0);

    // flush with rd=9 pending; concurrent issue to rd=12 dropped
    idle(); issue(5'd9, 3'd5); tick(0);
    no_issue(); settle();
    chk("flush_pre_busy", 16'(busy), 16'h1);
    tick(0);
    flush = 1; issue(5'd12, 3'd3); id_rs = {5'd0, 5'd9}; settle();
    chk("flush_cycle_stall", 16'(stall), 16'h1);
    tick(1);
    flush = 0; no_issue(); id_rs = {5'd12, 5'd9}; settle();
    chk("flush_after_stall", 16'(stall), 16'h0);
    chk("flush_after_busy", 16'(busy), 16'h0);
    chk("flush_keeps_cnt", stall_cnt, exp_stats());
    tick(0);

    // async reset mid-operation
    idle(); issue(5'd9, 3'd7); tick(0);
    no_issue(); id_rs = {5'd0, 5'd9}; settle();
    chk("rst_pre_stall", 16'(stall), 16'h1);
    tick(1);
    rst_n = 0; #1;
    exp_cnt = 0;
    chk("rst_mid_busy", 16'(busy), 16'h0);
    chk("rst_mid_stall", 16'(stall), 16'h0);
    chk("rst_mid_cnt", stall_cnt, 16'h0);
    @(posedge clk); #1;
    rst_n = 1;
    settle();
    chk("rst_post_stall", 16'(stall), 16'h0);
    tick(0);

    // three scoreboard stalls counted from zero
    idle(); issue(5'd9, 3'd3); tick(0);
    no_issue(); id_rs = {5'd0, 5'd9};
    repeat (3) begin
      settle();
      chk("cnt3_stall", 16'(stall), 16'h1);
      tick(1);
    end
    idle(); settle();
    chk("cnt3_value", stall_cnt, exp_stats());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
